// File: rtl/uvmt_cv32e40x_sl_trigger_csr_shadow_pkg.sv
// Shared trigger-CSR definitions: CSR codes, CSR addresses, reset values
// and the masked-write merge used by every shadow register.
package uvmt_cv32e40x_base_test_pkg;

  typedef enum logic [1:0] {
    TSEL   = 2'd0,
    TDATA1 = 2'd1,
    TDATA2 = 2'd2
  } trig_csr_e;

  localparam logic [11:0] CSR_TSELECT_ADDR = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1_ADDR  = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2_ADDR  = 12'h7A2;

  localparam logic [31:0] TDATA1_RESET = 32'h2800_1000;
  localparam logic [31:0] TDATA2_RESET = 32'h0000_0000;

  // Bits set in wmask come from wdata, the rest keep the old value.
  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] wmask,
                                         input logic [31:0] wdata);
    return (old_v & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_sl_trigger_csr_shadow_if.sv
// RVFI view of one retired instruction's trigger-CSR accesses.
interface uvmt_cv32e40x_sl_trigger_csr_shadow_if;
  logic        rvfi_valid_i;
  logic [31:0] tselect_wmask_i, tselect_wdata_i, tselect_rmask_i, tselect_rdata_i;
  logic [31:0] tdata1_wmask_i,  tdata1_wdata_i,  tdata1_rmask_i,  tdata1_rdata_i;
  logic [31:0] tdata2_wmask_i,  tdata2_wdata_i,  tdata2_rmask_i,  tdata2_rdata_i;

  modport master (
    output rvfi_valid_i,
    output tselect_wmask_i, tselect_wdata_i, tselect_rmask_i, tselect_rdata_i,
    output tdata1_wmask_i,  tdata1_wdata_i,  tdata1_rmask_i,  tdata1_rdata_i,
    output tdata2_wmask_i,  tdata2_wdata_i,  tdata2_rmask_i,  tdata2_rdata_i
  );

  modport slave (
    input rvfi_valid_i,
    input tselect_wmask_i, tselect_wdata_i, tselect_rmask_i, tselect_rdata_i,
    input tdata1_wmask_i,  tdata1_wdata_i,  tdata1_rmask_i,  tdata1_rdata_i,
    input tdata2_wmask_i,  tdata2_wdata_i,  tdata2_rmask_i,  tdata2_rdata_i
  );
endinterface

// File: rtl/uvmt_cv32e40x_sl_trigger_csr_shadow_entry.sv
// Shadow tdata1/tdata2 pair for a single trigger.
module uvmt_cv32e40x_sl_trigger_csr_entry
  import uvmt_cv32e40x_base_test_pkg::*;
#(
  parameter logic [31:0] T1_RESET = TDATA1_RESET,
  parameter logic [31:0] T2_RESET = TDATA2_RESET
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel,
  input  logic [31:0] t1_wmask,
  input  logic [31:0] t1_wdata,
  input  logic [31:0] t2_wmask,
  input  logic [31:0] t2_wdata,
  output logic [31:0] tdata1,
  output logic [31:0] tdata2
);

  // Masked write when this trigger is the one selected by the retiring instruction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tdata1 <= T1_RESET;
      tdata2 <= T2_RESET;
    end else if (sel) begin
      tdata1 <= wmerge(tdata1, t1_wmask, t1_wdata);
      tdata2 <= wmerge(tdata2, t2_wmask, t2_wdata);
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_sl_trigger_csr_shadow.sv
// Trigger CSR shadow: tracks retired tselect/tdata1/tdata2 writes, keeps a
// per-trigger copy and flags RVFI reads that disagree with it.
module uvmt_cv32e40x_sl_trigger_csr_shadow
  import uvmt_cv32e40x_base_test_pkg::*;
#(
  parameter int          NUM_TRIGGERS = 4,
  parameter logic [31:0] TDATA1_RST   = TDATA1_RESET,
  parameter logic [31:0] TDATA2_RST   = TDATA2_RESET,
  localparam int         TSW          = $clog2(NUM_TRIGGERS) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  uvmt_cv32e40x_sl_trigger_csr_shadow_if.slave rvfi,
  output logic [TSW-1:0]                 tselect_o,
  output logic [NUM_TRIGGERS-1:0][31:0]  tdata1_array_o,
  output logic [NUM_TRIGGERS-1:0][31:0]  tdata2_array_o,
  output logic                           mismatch_o,
  output trig_csr_e                      mismatch_csr_o,
  output logic                           illegal_tsel_o
);

  logic [31:0] tsel_ext, tsel_new, cur_t1, cur_t2;
  logic        in_range, tsel_illegal;
  logic        mm_tsel, mm_t1, mm_t2;

  assign tsel_ext     = 32'(tselect_o);
  assign in_range     = tsel_ext < 32'(NUM_TRIGGERS);
  assign tsel_new     = wmerge(tsel_ext, rvfi.tselect_wmask_i, rvfi.tselect_wdata_i);
  assign tsel_illegal = tsel_new >= 32'(NUM_TRIGGERS);

  // Pick the entry addressed by the pre-instruction tselect for read checking.
  always_comb begin
    cur_t1 = '0;
    cur_t2 = '0;
    for (int i = 0; i < NUM_TRIGGERS; i++) begin
      if (tsel_ext == 32'(i)) begin
        cur_t1 = tdata1_array_o[i];
        cur_t2 = tdata2_array_o[i];
      end
    end
  end

  // Out-of-range tselect leaves tdataN reads unchecked.
  assign mm_tsel = |((rvfi.tselect_rdata_i ^ tsel_ext) & rvfi.tselect_rmask_i);
  assign mm_t1   = in_range && |((rvfi.tdata1_rdata_i ^ cur_t1) & rvfi.tdata1_rmask_i);
  assign mm_t2   = in_range && |((rvfi.tdata2_rdata_i ^ cur_t2) & rvfi.tdata2_rmask_i);

  // tselect only accepts values naming an implemented trigger.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      tselect_o <= '0;
    else if (rvfi.rvfi_valid_i && !tsel_illegal)
      tselect_o <= tsel_new[TSW-1:0];
  end

  // One-cycle status pulses; lowest CSR code wins when several reads diverge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_o     <= 1'b0;
      mismatch_csr_o <= TSEL;
      illegal_tsel_o <= 1'b0;
    end else begin
      mismatch_o     <= rvfi.rvfi_valid_i && (mm_tsel || mm_t1 || mm_t2);
      mismatch_csr_o <= TSEL;
      if (rvfi.rvfi_valid_i && !mm_tsel) begin
        if (mm_t1)      mismatch_csr_o <= TDATA1;
        else if (mm_t2) mismatch_csr_o <= TDATA2;
      end
      illegal_tsel_o <= rvfi.rvfi_valid_i && tsel_illegal;
    end
  end

  // tdataN writes land in the entry named by the old tselect.
  for (genvar g = 0; g < NUM_TRIGGERS; g++) begin : g_entry
    uvmt_cv32e40x_sl_trigger_csr_entry #(
      .T1_RESET (TDATA1_RST),
      .T2_RESET (TDATA2_RST)
    ) u_entry (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .sel      (rvfi.rvfi_valid_i && in_range && (tsel_ext == 32'(g))),
      .t1_wmask (rvfi.tdata1_wmask_i),
      .t1_wdata (rvfi.tdata1_wdata_i),
      .t2_wmask (rvfi.tdata2_wmask_i),
      .t2_wdata (rvfi.tdata2_wdata_i),
      .tdata1   (tdata1_array_o[g]),
      .tdata2   (tdata2_array_o[g])
    );
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_csr_shadow.sv
// Bench for the trigger CSR shadow: directed table plus random RVFI stream
// checked against a behavioural model of the trigger CSR file.
module tb_uvmt_cv32e40x_sl_trigger_csr_shadow;
  import uvmt_cv32e40x_base_test_pkg::*;

  localparam int NT  = 2;
  localparam int TSW = $clog2(NT) + 1;
  localparam logic [31:0] R = 32'h2800_1000;
  localparam logic [31:0] F = 32'hffff_ffff;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [TSW-1:0]       tselect_o;
  logic [NT-1:0][31:0]  tdata1_array_o, tdata2_array_o;
  logic                 mismatch_o, illegal_tsel_o;
  trig_csr_e            mismatch_csr_o;

  uvmt_cv32e40x_sl_trigger_csr_shadow_if rvfi ();

  uvmt_cv32e40x_sl_trigger_csr_shadow #(.NUM_TRIGGERS(NT)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rvfi           (rvfi),
    .tselect_o      (tselect_o),
    .tdata1_array_o (tdata1_array_o),
    .tdata2_array_o (tdata2_array_o),
    .mismatch_o     (mismatch_o),
    .mismatch_csr_o (mismatch_csr_o),
    .illegal_tsel_o (illegal_tsel_o)
  );

  always #5 clk_i = ~clk_i;

  // Stimulus fields (s=tselect, a=tdata1, b=tdata2; w=wmask d=wdata m=rmask r=rdata)
  // followed by expected state after the edge.
  typedef struct {
    bit rst, vld;
    logic [31:0] sw, sd, sm, sr, aw, ad, am, ar, bw, bd, bm, br;
    logic [31:0] e_sel, e_t1_0, e_t1_1, e_t2_0, e_t2_1;
    bit e_mm; int e_csr; bit e_ill;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: the architectural CSR file as plain variables.
  int          m_sel;
  logic [31:0] m_t1 [NT];
  logic [31:0] m_t2 [NT];
  bit          m_mm, m_ill;
  int          m_csr;

  function automatic logic [31:0] mrg(logic [31:0] o, logic [31:0] m, logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = m[b] ? d[b] : o[b];
    return r;
  endfunction

  task automatic model_step(input vec_t v);
    int nsel, old;
    bit d0, d1, d2;
    if (v.rst) begin
      m_sel = 0; m_mm = 0; m_ill = 0; m_csr = 0;
      for (int i = 0; i < NT; i++) begin m_t1[i] = R; m_t2[i] = 0; end
    end else if (!v.vld) begin
      m_mm = 0; m_ill = 0; m_csr = 0;
    end else begin
      old = m_sel;
      d0 = ((v.sr ^ 32'(m_sel)) & v.sm) != 0;
      d1 = (m_sel < NT) && (((v.ar ^ m_t1[m_sel]) & v.am) != 0);
      d2 = (m_sel < NT) && (((v.br ^ m_t2[m_sel]) & v.bm) != 0);
      m_mm  = d0 || d1 || d2;
      m_csr = d0 ? 0 : d1 ? 1 : d2 ? 2 : 0;
      nsel  = int'(mrg(32'(m_sel), v.sw, v.sd));
      m_ill = (nsel < 0) || (nsel >= NT);
      if (!m_ill) m_sel = nsel;
      if (old < NT) begin
        m_t1[old] = mrg(m_t1[old], v.aw, v.ad);
        m_t2[old] = mrg(m_t2[old], v.bw, v.bd);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk_i);
    rst_i = v.rst;
    rvfi.rvfi_valid_i    = v.vld;
    rvfi.tselect_wmask_i = v.sw; rvfi.tselect_wdata_i = v.sd;
    rvfi.tselect_rmask_i = v.sm; rvfi.tselect_rdata_i = v.sr;
    rvfi.tdata1_wmask_i  = v.aw; rvfi.tdata1_wdata_i  = v.ad;
    rvfi.tdata1_rmask_i  = v.am; rvfi.tdata1_rdata_i  = v.ar;
    rvfi.tdata2_wmask_i  = v.bw; rvfi.tdata2_wdata_i  = v.bd;
    rvfi.tdata2_rmask_i  = v.bm; rvfi.tdata2_rdata_i  = v.br;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_vs_model(input string tag);
    chk({tag, ".tsel"},  32'(tselect_o), 32'(m_sel));
    for (int i = 0; i < NT; i++) begin
      chk($sformatf("%s.t1[%0d]", tag, i), tdata1_array_o[i], m_t1[i]);
      chk($sformatf("%s.t2[%0d]", tag, i), tdata2_array_o[i], m_t2[i]);
    end
    chk({tag, ".mm"},  32'(mismatch_o),     32'(m_mm));
    chk({tag, ".csr"}, 32'(mismatch_csr_o), 32'(m_csr));
    chk({tag, ".ill"}, 32'(illegal_tsel_o), 32'(m_ill));
  endtask

  vec_t tbl [15];

  function automatic logic [31:0] rmask_pick();
    case ($urandom_range(0, 3))
      0, 1:    return 32'h0;
      2:       return F;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t v;
    //        rst vld  sw sd       sm  sr    aw            ad            am            ar            bw bd            bm     br      e_sel t1_0          t1_1          t2_0 t2_1          mm csr ill
    tbl[0]  = '{1, 0,  0, 0,       0,  0,    0,            0,            0,            0,            0, 0,            0,     0,      0,    R,            R,            0,   0,            0, 0,  0};
    tbl[1]  = '{0, 0,  F, 1,       0,  0,    F,            32'hdead,     0,            0,            0, 0,            0,     0,      0,    R,            R,            0,   0,            0, 0,  0};
    tbl[2]  = '{0, 1,  F, 1,       0,  0,    0,            0,            0,            0,            0, 0,            0,     0,      1,    R,            R,            0,   0,            0, 0,  0};
    tbl[3]  = '{0, 1,  0, 0,       0,  0,    0,            0,            0,            0,            F, 32'h80000100, 0,     0,      1,    R,            R,            0,   32'h80000100, 0, 0,  0};
    tbl[4]  = '{0, 1,  F, 5,       0,  0,    0,            0,            0,            0,            0, 0,            0,     0,      1,    R,            R,            0,   32'h80000100, 0, 0,  1};
    tbl[5]  = '{0, 1,  0, 0,       0,  0,    0,            0,            F,            32'h60001044, 0, 0,            0,     0,      1,    R,            R,            0,   32'h80000100, 1, 1,  0};
    tbl[6]  = '{0, 1,  0, 0,       0,  0,    0,            0,            0,            0,            0, 0,            0,     0,      1,    R,            R,            0,   32'h80000100, 0, 0,  0};
    tbl[7]  = '{0, 1,  0, 0,       0,  0,    F,            32'h60001044, F,            R,            0, 0,            0,     0,      1,    R,            32'h60001044, 0,   32'h80000100, 0, 0,  0};
    tbl[8]  = '{1, 1,  0, 0,       0,  0,    F,            32'h12345678, 0,            0,            0, 0,            0,     0,      0,    R,            R,            0,   0,            0, 0,  0};
    tbl[9]  = '{0, 1,  0, 0,       1,  1,    0,            0,            0,            0,            0, 0,            32'hff, 5,      0,    R,            R,            0,   0,            1, 0,  0};
    tbl[10] = '{0, 1,  0, 0,       0,  0,    32'h0000ffff, 32'habcd5555, 0,            0,            0, 0,            0,     0,      0,    32'h28005555, R,            0,   0,            0, 0,  0};
    tbl[11] = '{0, 1,  F, 1,       0,  0,    F,            32'h11111111, 0,            0,            0, 0,            0,     0,      1,    32'h11111111, R,            0,   0,            0, 0,  0};
    tbl[12] = '{0, 1,  0, 0,       0,  0,    0,            0,            32'h0000ff00, 32'hffff10ff, 0, 0,            0,     F,      1,    32'h11111111, R,            0,   0,            0, 0,  0};
    tbl[13] = '{0, 1,  1, 2,       0,  0,    0,            0,            0,            0,            0, 0,            0,     0,      0,    32'h11111111, R,            0,   0,            0, 0,  0};
    tbl[14] = '{0, 1,  0, 0,       0,  0,    0,            0,            0,            0,            0, 0,            F,     4,      0,    32'h11111111, R,            0,   0,            1, 2,  0};

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i]);
      model_step(tbl[i]);
      chk($sformatf("v%0d.tsel", i),  32'(tselect_o),      tbl[i].e_sel);
      chk($sformatf("v%0d.t1[0]", i), tdata1_array_o[0],   tbl[i].e_t1_0);
      chk($sformatf("v%0d.t1[1]", i), tdata1_array_o[1],   tbl[i].e_t1_1);
      chk($sformatf("v%0d.t2[0]", i), tdata2_array_o[0],   tbl[i].e_t2_0);
      chk($sformatf("v%0d.t2[1]", i), tdata2_array_o[1],   tbl[i].e_t2_1);
      chk($sformatf("v%0d.mm", i),    32'(mismatch_o),     32'(tbl[i].e_mm));
      chk($sformatf("v%0d.csr", i),   32'(mismatch_csr_o), 32'(tbl[i].e_csr));
      chk($sformatf("v%0d.ill", i),   32'(illegal_tsel_o), 32'(tbl[i].e_ill));
    end

    // Random retire stream; reads usually echo the true CSR value, sometimes corrupted.
    for (int n = 0; n < 400; n++) begin
      v = tbl[6];
      v.rst = ($urandom_range(0, 49) == 0);
      v.vld = ($urandom_range(0, 3) != 0);
      v.sw = ($urandom_range(0, 2) == 0) ? F : 32'h0;
      v.sd = $urandom_range(0, 3);
      v.aw = rmask_pick(); v.ad = $urandom;
      v.bw = rmask_pick(); v.bd = $urandom;
      v.sm = rmask_pick(); v.am = rmask_pick(); v.bm = rmask_pick();
      v.sr = 32'(m_sel);
      v.ar = (m_sel < NT) ? m_t1[m_sel] : 32'h0;
      v.br = (m_sel < NT) ? m_t2[m_sel] : 32'h0;
      if ($urandom_range(0, 5) == 0) v.sr ^= 32'(1) << $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) v.ar ^= 32'(1) << $urandom_range(0, 31);
      if ($urandom_range(0, 5) == 0) v.br ^= 32'(1) << $urandom_range(0, 31);
      apply(v);
      model_step(v);
      chk_vs_model($sformatf("r%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
